// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM->WB stage: load op codes, register bus widths and the zero word.
// Also provides the `RegBus / `RegAddrBus text macros used by older parts of the core.
`ifndef MEM_WB_STAGE_DEFINES
`define MEM_WB_STAGE_DEFINES
`define RegBus      31:0
`define RegAddrBus  4:0
`endif

package mem_wb_stage_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_W-1:0] ZERO_WORD = '0;

    typedef enum logic [2:0] {
        LOAD_LW  = 3'b000,
        LOAD_LB  = 3'b001,
        LOAD_LBU = 3'b010,
        LOAD_LH  = 3'b011,
        LOAD_LHU = 3'b100,
        LOAD_LWL = 3'b101,
        LOAD_LWR = 3'b110
    } load_op_e;

endpackage

// File: rtl/wb_load_align.sv
// Combinational big-endian load aligner: picks and extends the addressed byte/halfword of a RAM word.
// LWL/LWR merging with the old rt value is generated only when WB_LWL_LWR_EN is defined.
module wb_load_align #(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        op,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] word,
    input  logic [DATA_W-1:0] rt,
    output logic [DATA_W-1:0] data
);
    import mem_wb_stage_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte k of a big-endian word sits in the most significant end for k=0.
    always_comb begin
        byte_sel = word[DATA_W-1-8*offset -: 8];
        half_sel = offset[1] ? word[15:0] : word[DATA_W-1 -: 16];
    end

`ifdef WB_LWL_LWR_EN
    logic [4:0]        left_sh;
    logic [4:0]        right_sh;
    logic [DATA_W-1:0] lwl_data;
    logic [DATA_W-1:0] lwr_data;

    always_comb begin
        left_sh  = {offset, 3'b000};
        right_sh = {~offset, 3'b000};
        lwl_data = (word << left_sh) | (rt & ~({DATA_W{1'b1}} << left_sh));
        lwr_data = (word >> right_sh) | (rt & ~({DATA_W{1'b1}} >> right_sh));
    end
`else
    logic unused_rt;
    assign unused_rt = ^rt;
`endif

    always_comb begin
        data = word;
        case (op)
            LOAD_LB:  data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LOAD_LBU: data = {{(DATA_W-8){1'b0}}, byte_sel};
            LOAD_LH:  data = {{(DATA_W-16){half_sel[15]}}, half_sel};
            LOAD_LHU: data = {{(DATA_W-16){1'b0}}, half_sel};
`ifdef WB_LWL_LWR_EN
            LOAD_LWL: data = lwl_data;
            LOAD_LWR: data = lwr_data;
`endif
            default:  data = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register and write-back: captures MEM results, aligns load data, drives regfile write port.
// Optional macro WB_LWL_LWR_EN enables LWL/LWR merging in the load aligner.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall_mem,
    input  logic              stall_wb,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_load,
    input  logic [2:0]        mem_load_op,
    input  logic [1:0]        mem_addr_lo,
    input  logic [DATA_W-1:0] dram_rdata,
    output logic              wb_wreg,
    output logic [ADDR_W-1:0] wb_wd,
    output logic [DATA_W-1:0] wb_wdata
);
    import mem_wb_stage_pkg::*;

    logic              wreg_q;
    logic [ADDR_W-1:0] wd_q;
    logic [DATA_W-1:0] wdata_q;
    logic              load_q;
    load_op_e          op_q;
    logic [1:0]        off_q;
    logic [DATA_W-1:0] hold_q;
    logic              held_q;

    logic [DATA_W-1:0] load_word;
    logic [DATA_W-1:0] aligned;

    // The RAM word is only valid in the first WB cycle, so a stalled load keeps its own copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wreg_q  <= 1'b0;
            wd_q    <= '0;
            wdata_q <= '0;
            load_q  <= 1'b0;
            op_q    <= LOAD_LW;
            off_q   <= 2'b00;
            hold_q  <= '0;
            held_q  <= 1'b0;
        end else if (flush) begin
            wreg_q  <= 1'b0;
            wd_q    <= '0;
            wdata_q <= '0;
            load_q  <= 1'b0;
            op_q    <= LOAD_LW;
            off_q   <= 2'b00;
            held_q  <= 1'b0;
        end else if (stall_wb) begin
            if (load_q && !held_q) begin
                hold_q <= dram_rdata;
                held_q <= 1'b1;
            end
        end else if (stall_mem) begin
            wreg_q  <= 1'b0;
            wd_q    <= '0;
            wdata_q <= '0;
            load_q  <= 1'b0;
            op_q    <= LOAD_LW;
            off_q   <= 2'b00;
            held_q  <= 1'b0;
        end else begin
            wreg_q  <= mem_wreg;
            wd_q    <= mem_wd;
            wdata_q <= mem_wdata;
            load_q  <= mem_load;
            op_q    <= load_op_e'(mem_load_op);
            off_q   <= mem_addr_lo;
            held_q  <= 1'b0;
        end
    end

    assign load_word = held_q ? hold_q : dram_rdata;

    wb_load_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .op     (op_q),
        .offset (off_q),
        .word   (load_word),
        .rt     (wdata_q),
        .data   (aligned)
    );

    assign wb_wreg  = wreg_q;
    assign wb_wd    = wd_q;
    assign wb_wdata = load_q ? aligned : wdata_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table, directed stall/flush/reset sequences, randomized model check.
// Expectations for op 101/110 follow WB_LWL_LWR_EN.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        stall_mem;
    logic        stall_wb;
    logic        mem_wreg;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata;
    logic        mem_load;
    logic [2:0]  mem_load_op;
    logic [1:0]  mem_addr_lo;
    logic [31:0] dram_rdata;
    logic        wb_wreg;
    logic [4:0]  wb_wd;
    logic [31:0] wb_wdata;

    int passCount  = 0;
    int totalCount = 0;

    mem_wb_stage #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .stall_mem   (stall_mem),
        .stall_wb    (stall_wb),
        .mem_wreg    (mem_wreg),
        .mem_wd      (mem_wd),
        .mem_wdata   (mem_wdata),
        .mem_load    (mem_load),
        .mem_load_op (mem_load_op),
        .mem_addr_lo (mem_addr_lo),
        .dram_rdata  (dram_rdata),
        .wb_wreg     (wb_wreg),
        .wb_wd       (wb_wd),
        .wb_wdata    (wb_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        load;
        bit [2:0]  op;
        bit [1:0]  off;
        bit [31:0] rdata;
        bit [31:0] rt;
        bit [31:0] expect_data;
        string     name;
    } vec_t;

    typedef struct {
        bit        wreg;
        bit [4:0]  wd;
        bit [31:0] wdata;
        bit        load;
        bit [2:0]  op;
        bit [1:0]  off;
    } entry_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        totalCount++;
        if (actual !== required)
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        else
            passCount++;
    endtask

    task automatic applyStimulus(input bit wreg, input bit [4:0] wd, input bit [31:0] wdata,
                                 input bit load, input bit [2:0] op, input bit [1:0] off,
                                 input bit [31:0] rdata);
        mem_wreg    = wreg;
        mem_wd      = wd;
        mem_wdata   = wdata;
        mem_load    = load;
        mem_load_op = op;
        mem_addr_lo = off;
        dram_rdata  = rdata;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: interpret the word as four big-endian bytes and apply the load rules arithmetically.
    function automatic bit [31:0] refAlign(input bit [2:0] op, input bit [1:0] k,
                                           input bit [31:0] w, input bit [31:0] rt);
        longint unsigned b;
        longint unsigned h;
        longint unsigned wl;
        longint unsigned rl;
        longint unsigned kk;
        wl = longint'(w);
        rl = longint'(rt);
        kk = longint'(k);
        b  = (wl >> (24 - 8 * kk)) % 256;
        h  = (k >= 2) ? (wl % 65536) : (wl / 65536);
        case (op)
            3'd1: return 32'(b >= 128 ? b + 64'hFFFF_FF00 : b);
            3'd2: return 32'(b);
            3'd3: return 32'(h >= 32768 ? h + 64'hFFFF_0000 : h);
            3'd4: return 32'(h);
`ifdef WB_LWL_LWR_EN
            3'd5: return 32'((wl << (8 * kk)) + (rl % (64'd1 << (8 * kk))));
            3'd6: return 32'((wl >> (8 * (3 - kk))) + ((rl >> (8 * (kk + 1))) << (8 * (kk + 1))));
`endif
            default: return w;
        endcase
    endfunction

    initial begin
        entry_t     m_entry;
        entry_t     empty_entry;
        bit         m_fresh;
        bit [31:0]  m_held;
        bit [31:0]  exp_data;
        bit [31:0]  lwl_exp;
        bit [31:0]  lwr_exp;

`ifdef WB_LWL_LWR_EN
        lwl_exp = 32'hBBCC_DD44;
        lwr_exp = 32'h1122_AABB;
`else
        lwl_exp = 32'hAABB_CCDD;
        lwr_exp = 32'hAABB_CCDD;
`endif
        vecs[0] = '{1'b0, 3'd0, 2'd0, 32'h0,         32'h1234_5678, 32'h1234_5678, "alu"};
        vecs[1] = '{1'b1, 3'd1, 2'd1, 32'h8081_7F22, 32'h0,         32'hFFFF_FF81, "lb_off1"};
        vecs[2] = '{1'b1, 3'd2, 2'd2, 32'h8081_7F22, 32'h0,         32'h0000_007F, "lbu_off2"};
        vecs[3] = '{1'b1, 3'd3, 2'd2, 32'h8081_7F22, 32'h0,         32'h0000_7F22, "lh_off2"};
        vecs[4] = '{1'b1, 3'd4, 2'd0, 32'h8081_7F22, 32'h0,         32'h0000_8081, "lhu_off0"};
        vecs[5] = '{1'b1, 3'd0, 2'd3, 32'h8081_7F22, 32'h0,         32'h8081_7F22, "lw_off3"};
        vecs[6] = '{1'b1, 3'd5, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, lwl_exp,       "lwl_off1"};
        vecs[7] = '{1'b1, 3'd6, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, lwr_exp,       "lwr_off1"};
        vecs[8] = '{1'b1, 3'd7, 2'd2, 32'hAABB_CCDD, 32'h0,         32'hAABB_CCDD, "reserved_op"};
        vecs[9] = '{1'b1, 3'd1, 2'd3, 32'h8081_7F22, 32'h0,         32'h0000_0022, "lb_off3"};

        rst = 1'b0;
        flush = 1'b0;
        stall_mem = 1'b0;
        stall_wb = 1'b0;
        applyStimulus(1'b1, 5'd3, 32'hFFFF_FFFF, 1'b0, 3'd0, 2'd0, 32'h0);
        tick();
        tick();
        checkOutput("reset_wreg", 32'(wb_wreg), 32'd0);
        checkOutput("reset_wd", 32'(wb_wd), 32'd0);
        checkOutput("reset_wdata", wb_wdata, 32'd0);
        rst = 1'b1;

        // Table-driven single-cycle captures, no stalls.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 5'(i + 1), vecs[i].rt, vecs[i].load, vecs[i].op, vecs[i].off, vecs[i].rdata);
            if (!vecs[i].load) mem_wdata = vecs[i].expect_data;
            tick();
            checkOutput({vecs[i].name, "_wreg"}, 32'(wb_wreg), 32'd1);
            checkOutput({vecs[i].name, "_wd"}, 32'(wb_wd), 32'(i + 1));
            checkOutput({vecs[i].name, "_wdata"}, wb_wdata, vecs[i].expect_data);
        end

        // Stall hold: RAM word changes while WB is stalled, held copy must win.
        applyStimulus(1'b1, 5'd7, 32'h0, 1'b1, 3'd0, 2'd0, 32'h8081_7F22);
        tick();
        stall_wb = 1'b1;
        checkOutput("hold_c0_wdata", wb_wdata, 32'h8081_7F22);
        for (int c = 1; c <= 3; c++) begin
            tick();
            dram_rdata = 32'hDEAD_BEEF;
            mem_wreg = 1'b0;
            #1;
            checkOutput("hold_wdata", wb_wdata, 32'h8081_7F22);
            checkOutput("hold_wreg", 32'(wb_wreg), 32'd1);
        end
        stall_wb = 1'b0;

        // Bubble from a stalled MEM stage.
        applyStimulus(1'b1, 5'd9, 32'h5555_AAAA, 1'b0, 3'd0, 2'd0, 32'h0);
        tick();
        checkOutput("pre_bubble_wreg", 32'(wb_wreg), 32'd1);
        stall_mem = 1'b1;
        tick();
        checkOutput("bubble_wreg", 32'(wb_wreg), 32'd0);
        checkOutput("bubble_wdata", wb_wdata, 32'd0);
        stall_mem = 1'b0;

        // Flush beats stall_wb.
        tick();
        checkOutput("pre_flush_wreg", 32'(wb_wreg), 32'd1);
        flush = 1'b1;
        stall_wb = 1'b1;
        tick();
        checkOutput("flush_wreg", 32'(wb_wreg), 32'd0);
        flush = 1'b0;
        stall_wb = 1'b0;

        // Asynchronous reset in the middle of a write.
        applyStimulus(1'b1, 5'd12, 32'hCAFE_0001, 1'b0, 3'd0, 2'd0, 32'h0);
        tick();
        checkOutput("pre_reset_wreg", 32'(wb_wreg), 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_reset_wreg", 32'(wb_wreg), 32'd0);
        checkOutput("async_reset_wd", 32'(wb_wd), 32'd0);
        checkOutput("async_reset_wdata", wb_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        stall_mem = 1'b1;
        tick();
        checkOutput("post_release_wreg", 32'(wb_wreg), 32'd0);
        stall_mem = 1'b0;
        tick();
        checkOutput("first_advance_wreg", 32'(wb_wreg), 32'd1);
        checkOutput("first_advance_wdata", wb_wdata, 32'hCAFE_0001);

        // Randomized run against the reference model.
        rst = 1'b0;
        #1 rst = 1'b1;
        empty_entry = '{1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0};
        m_entry = empty_entry;
        m_fresh = 1'b0;
        m_held  = 32'd0;
        for (int n = 0; n < 400; n++) begin
            flush     = ($urandom_range(0, 15) == 0);
            stall_wb  = ($urandom_range(0, 3) == 0);
            stall_mem = ($urandom_range(0, 5) == 0);
            applyStimulus(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 3'($urandom),
                          2'($urandom), $urandom);
            if (flush) begin
                m_entry = empty_entry;
                m_fresh = 1'b0;
            end else if (stall_wb) begin
                if (m_fresh) m_held = dram_rdata;
                m_fresh = 1'b0;
            end else if (stall_mem) begin
                m_entry = empty_entry;
                m_fresh = 1'b0;
            end else begin
                m_entry = '{mem_wreg, mem_wd, mem_wdata, mem_load, mem_load_op, mem_addr_lo};
                m_fresh = 1'b1;
            end
            tick();
            dram_rdata = $urandom;
            #1;
            if (m_entry.load)
                exp_data = refAlign(m_entry.op, m_entry.off, m_fresh ? dram_rdata : m_held, m_entry.wdata);
            else
                exp_data = m_entry.wdata;
            checkOutput("rand_wreg", 32'(wb_wreg), 32'(m_entry.wreg));
            checkOutput("rand_wd", 32'(wb_wd), 32'(m_entry.wd));
            checkOutput("rand_wdata", wb_wdata, exp_data);
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
